// File: rtl/dct_pkg.sv
// Shared constants and types for the 4-point DCT datapath and its transpose buffer.
// Used by dct_transpose_buf (optional feature macro: DCT_TBUF_PINGPONG_EN).
package dct_pkg;

    localparam int DCT_N        = 4;
    localparam int DCT_SAMPLE_W = 8;
    localparam int DCT_IDX_W    = $clog2(DCT_N);

    typedef logic signed [DCT_SAMPLE_W-1:0] dct_sample_t;
    typedef dct_sample_t [0:DCT_N-1]        dct_vec_t;
    typedef logic [DCT_IDX_W-1:0]           dct_idx_t;

    // Row/column index step that wraps back to 0 after the last position of a block.
    function automatic dct_idx_t dct_idx_next(input dct_idx_t idx);
        return (idx == dct_idx_t'(DCT_N - 1)) ? dct_idx_t'(0) : idx + dct_idx_t'(1);
    endfunction

endpackage

// File: rtl/dct_tbuf_bank.sv
// One N x N sample store of the transpose buffer: written a row at a time,
// read a column at a time.
module dct_tbuf_bank
    import dct_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  dct_idx_t row,
    input  dct_vec_t dt,
    input  dct_idx_t col,
    output dct_vec_t col_dt
);

    dct_vec_t mem [0:DCT_N-1];

    // Row write port; contents are cleared on reset so a discarded block cannot leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DCT_N; r++) begin
                mem[r] <= '0;
            end
        end else if (we) begin
            mem[row] <= dt;
        end
    end

    // Column read: element k of the result is row k of the stored block.
    always_comb begin
        col_dt = '0;
        for (int k = 0; k < DCT_N; k++) begin
            col_dt[k] = mem[k][col];
        end
    end

endmodule

// File: rtl/dct_transpose_buf.sv
// 4x4 block transpose buffer in front of the 1-D DCT: rows in, columns out.
// Define DCT_TBUF_PINGPONG_EN for a second bank so one block fills while the other drains.
module dct_transpose_buf
    import dct_pkg::*;
#(
    parameter int N        = DCT_N,
    parameter int SAMPLE_W = DCT_SAMPLE_W
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    input  dct_vec_t dt_i,
    input  logic     in_last_i,
    output logic     out_valid_o,
    input  logic     out_ready_i,
    output dct_vec_t dt_o,
    output logic     out_last_o,
    output logic     err_o
);

    localparam dct_idx_t    LAST_IDX    = dct_idx_t'(N - 1);
    localparam dct_sample_t ZERO_SAMPLE = dct_sample_t'({SAMPLE_W{1'b0}});

    dct_idx_t   wr_row;
    dct_idx_t   rd_col;
    logic       wb;
    logic       rb;
    logic [1:0] full;
    logic [1:0] full_next;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;
    logic       err;
    logic       in_fire;
    logic       out_fire;
    logic       wr_last;
    logic       rd_last;
    dct_vec_t   rd_vec [0:1];

    assign in_ready_o  = !rst_i && !full[wb];
    assign in_fire     = in_valid_i && in_ready_o;
    assign wr_last     = (wr_row == LAST_IDX);
    assign out_valid_o = full[rb];
    assign out_fire    = out_valid_o && out_ready_i;
    assign rd_last     = (rd_col == LAST_IDX);
    assign out_last_o  = out_valid_o && rd_last;
    assign err_o       = err;

`ifdef DCT_TBUF_PINGPONG_EN
    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tbuf_bank u_bank (
            .clk    (clk_i),
            .rst    (rst_i),
            .we     (in_fire && (wb == 1'(b))),
            .row    (wr_row),
            .dt     (dt_i),
            .col    (rd_col),
            .col_dt (rd_vec[b])
        );
    end

    // Bank pointers advance after the last row written and the last column read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb <= 1'b0;
            rb <= 1'b0;
        end else begin
            if (in_fire && wr_last) begin
                wb <= !wb;
            end
            if (out_fire && rd_last) begin
                rb <= !rb;
            end
        end
    end
`else
    dct_tbuf_bank u_bank (
        .clk    (clk_i),
        .rst    (rst_i),
        .we     (in_fire),
        .row    (wr_row),
        .dt     (dt_i),
        .col    (rd_col),
        .col_dt (rd_vec[0])
    );

    assign rd_vec[1] = '0;
    assign wb        = 1'b0;
    assign rb        = 1'b0;
`endif

    // Fill and drain of different banks may land in the same cycle; both take effect.
    always_comb begin
        set_mask  = (in_fire && wr_last)  ? (2'b01 << wb) : 2'b00;
        clr_mask  = (out_fire && rd_last) ? (2'b01 << rb) : 2'b00;
        full_next = (full | set_mask) & ~clr_mask;
    end

    // Counters, bank-full flags and the sticky framing error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_row <= '0;
            rd_col <= '0;
            full   <= 2'b00;
            err    <= 1'b0;
        end else begin
            full <= full_next;
            if (in_fire) begin
                wr_row <= dct_idx_next(wr_row);
                if (in_last_i != wr_last) begin
                    err <= 1'b1;
                end
            end
            if (out_fire) begin
                rd_col <= dct_idx_next(rd_col);
            end
        end
    end

    // Column output, forced to zero whenever no column is being offered.
    always_comb begin
        dt_o = rd_vec[rb];
        if (!out_valid_o) begin
            for (int k = 0; k < DCT_N; k++) begin
                dt_o[k] = ZERO_SAMPLE;
            end
        end else begin
            dt_o = rd_vec[rb];
        end
    end

endmodule
